// File: rtl/p192_pkg.sv
// Shared constants for the P-192 arithmetic blocks (multiplier and exponentiator).
package p192_pkg;

  localparam int K    = 192;
  localparam int LOGK = 8;

  localparam logic [K-1:0] M       = 192'hffffffffffffffff_fffffffffffffffe_ffffffffffffffff;
  localparam logic [K-1:0] MINUS_M = 192'h0000000000000000_0000000000000001_0000000000000001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/p192_modmul_seq_if.sv
// start/done multiply handshake between the exponentiation controller and the multiplier.
interface p192_modmul_seq_if;
  import p192_pkg::*;

  logic         start;
  logic [K-1:0] x;
  logic [K-1:0] y;
  logic [K-1:0] z;
  logic         done;

  modport master (output start, output x, output y, input z, input done);
  modport slave  (input start, input x, input y, output z, output done);

endinterface

// File: rtl/p192_modmul_seq_dbl_add_red.sv
// One interleaved step: r = (2*acc + (b ? yr : 0)) mod M, assuming acc, yr < M.
module p192_dbl_add_red
  import p192_pkg::*;
(
  input  logic [K-1:0] acc,
  input  logic [K-1:0] yr,
  input  logic         b,
  output logic [K-1:0] r
);

  localparam logic [K+1:0] M_EXT = {2'b00, M};

  logic [K+1:0] w_t;
  logic [K+1:0] w_t1;
  logic [K+1:0] w_t2;

  // t < 3M, so at most two subtractions bring it below M.
  always_comb begin
    w_t  = {1'b0, acc, 1'b0} + (b ? {2'b00, yr} : '0);
    w_t1 = (w_t  >= M_EXT) ? (w_t  - M_EXT) : w_t;
    w_t2 = (w_t1 >= M_EXT) ? (w_t1 - M_EXT) : w_t1;
  end

  assign r = w_t2[K-1:0];

endmodule

// File: rtl/p192_modmul_seq.sv
// Bit-serial MSB-first modular multiplier z = x*y mod M; done falls on accept, rises after K steps.
module p192_modmul_seq
  import p192_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  p192_modmul_seq_if.slave bus
);

  state_t            r_state, w_state_next;
  logic [K-1:0]      r_xr, w_xr_next;
  logic [K-1:0]      r_yr, w_yr_next;
  logic [K-1:0]      r_acc, w_acc_next;
  logic [LOGK-1:0]   r_cnt, w_cnt_next;
  logic [K-1:0]      r_z, w_z_next;
  logic              r_done, w_done_next;
  logic [K-1:0]      w_r;

  p192_dbl_add_red u_step (
    .acc (r_acc),
    .yr  (r_yr),
    .b   (r_xr[K-1]),
    .r   (w_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_xr    <= '0;
      r_yr    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_done  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_xr    <= w_xr_next;
      r_yr    <= w_yr_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_z     <= w_z_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_xr_next    = r_xr;
    w_yr_next    = r_yr;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_z_next     = r_z;
    w_done_next  = r_done;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_xr_next    = bus.x;
          w_yr_next    = bus.y;
          w_acc_next   = '0;
          w_cnt_next   = LOGK'(K - 1);
          w_done_next  = 1'b0;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_acc_next = w_r;
        w_xr_next  = r_xr << 1;
        // Counter reaching zero marks the step that consumes the last (LSB) operand bit.
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_z_next     = w_r;
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.z    = r_z;
  assign bus.done = r_done;

endmodule

// File: tb/tb_p192_modmul_seq.sv
// Directed-vector bench for p192_modmul_seq: latency, results, handshake corner cases, reset.
module tb_p192_modmul_seq;
  import p192_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n;

  p192_modmul_seq_if bus ();

  p192_modmul_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  // Drive one accept pulse; done must be low right after the accept edge.
  task automatic accept(input logic [K-1:0] xv, input logic [K-1:0] yv, input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    @(posedge clk);
    #1;
    check({tag, "_busy"}, K'(bus.done), K'(0));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen high; bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int cnt);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.done === 1'b1) break;
    end
  endtask

  initial begin
    logic [K-1:0] p96;
    logic [K-1:0] p191;
    logic [K-1:0] exp_pow;
    checks    = 0;
    errors    = 0;
    p96       = K'(1) << 96;
    p191      = K'(1) << 191;
    exp_pow   = 192'h0000000000000000_0000000000000001_0000000000000001;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", K'(bus.done), K'(1));
    check("rst_z", bus.z, '0);
    @(negedge clk);
    reset = 1'b0;

    // x=0 -> z=0, check exact latency
    accept('0, 192'h1234, "zero");
    wait_done(n);
    check("zero_lat", K'(n), K'(192));
    check("zero_z", bus.z, '0);
    $display("op x=0 y=1234: latency %0d z=%h", n, bus.z);

    accept(192'h1, 192'hdeadbeef, "one");
    wait_done(n);
    check("one_lat", K'(n), K'(192));
    check("one_z", bus.z, 192'hdeadbeef);
    $display("op x=1 y=deadbeef: latency %0d z=%h", n, bus.z);

    accept(p191, 192'h2, "p191");
    wait_done(n);
    check("p191_z", bus.z, exp_pow);
    $display("op x=2^191 y=2: latency %0d z=%h", n, bus.z);

    // M-1 squared with start held high; operands changed while busy must not matter
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = M - 1;
    bus.y     = M - 1;
    @(posedge clk);
    #1;
    check("m1_busy", K'(bus.done), K'(0));
    @(negedge clk);
    bus.x = p96;
    bus.y = p96;
    wait_done(n);
    check("m1_lat", K'(n), K'(192));
    check("m1_z", bus.z, 192'h1);
    $display("op x=y=M-1: latency %0d z=%h", n, bus.z);
    @(posedge clk);
    #1;
    check("b2b_accept", K'(bus.done), K'(0));
    check("b2b_z_hold", bus.z, 192'h1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    check("p96_lat", K'(n), K'(192));
    check("p96_z", bus.z, exp_pow);
    $display("op x=y=2^96 back-to-back: latency %0d z=%h", n, bus.z);

    // start pulsed while busy must be ignored
    accept(192'h5, 192'h7, "ign");
    repeat (49) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 192'h9;
    bus.y     = 192'h9;
    @(posedge clk);
    #1;
    check("ign_still_busy", K'(bus.done), K'(0));
    check("ign_z_stable", bus.z, exp_pow);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    check("ign_lat", K'(n), K'(142));
    check("ign_z", bus.z, 192'h23);
    repeat (3) @(posedge clk);
    #1;
    check("ign_single_done", K'(bus.done), K'(1));
    check("ign_single_z", bus.z, 192'h23);
    $display("op x=5 y=7 with mid-op start: remaining %0d z=%h", n, bus.z);

    // reset mid-operation discards the op
    accept(192'h1, 192'h5555, "rst");
    repeat (99) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_done", K'(bus.done), K'(1));
    check("midrst_z", bus.z, '0);
    @(negedge clk);
    reset = 1'b0;
    $display("reset at cycle 100: done=%0b z=%h", bus.done, bus.z);

    accept(192'h3, 192'h5, "post");
    wait_done(n);
    check("post_lat", K'(n), K'(192));
    check("post_z", bus.z, 192'hf);
    $display("op x=3 y=5 after reset: latency %0d z=%h", n, bus.z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
